// File: rtl/cpu_datapath.sv
// Datapath of the 8-bit microprocessor: PC, IR, accumulator, 16x8 register file,
// z/c flags and the ALU, all sequenced by strobes from the fetch/execute controller.
module cpu_datapath #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            CLK,
  input  logic            CLB,
  input  logic            aluControl,
  input  logic            LoadIR,
  input  logic            IncPC,
  input  logic            SelPC,
  input  logic            LoadPC,
  input  logic            LoadReg,
  input  logic            LoadAcc,
  input  logic [1:0]      SelAcc,
  input  logic [3:0]      SelALU,
  input  logic [7:0]      InstrIn,
  output logic [PC_W-1:0] PC,
  output logic [3:0]      Opcode,
  output logic            z,
  output logic            c,
  output logic [7:0]      AccOut
);

  localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_ir;
  logic [7:0]      r_acc;
  logic [7:0]      r_regs [16];
  logic            r_z;
  logic            r_c;

  logic [7:0]      w_rs_val;
  logic [7:0]      w_imm8;
  logic [7:0]      w_alu_res;
  logic            w_alu_c;
  logic [7:0]      w_acc_next;
  logic [PC_W-1:0] w_jump_src;
  logic            w_flag_en;

  // Returns {carry, result}; sub reports borrow as carry.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] res;
    case (op)
      4'b1000: res = {1'b0, a} + {1'b0, b};
      4'b1100: res = {(a < b), a - b};
      4'b0100: res = {1'b0, ~(a | b)};
      4'b0001: res = {a[7], a[6:0], 1'b0};
      4'b0011: res = {a[0], 1'b0, a[7:1]};
      default: res = {1'b0, a};
    endcase
    return res;
  endfunction

  // Operand fetch, ALU, accumulator mux and jump-source selection.
  always_comb begin
    w_rs_val               = r_regs[r_ir[3:0]];
    w_imm8                 = {4'h0, r_ir[3:0]};
    {w_alu_c, w_alu_res}   = alu_f(SelALU, r_acc, w_rs_val);
    case (SelAcc)
      2'b00:   w_acc_next = w_imm8;
      2'b01:   w_acc_next = w_rs_val;
      default: w_acc_next = w_alu_res;
    endcase
    if (SelPC) begin
      w_jump_src = w_rs_val[PC_W-1:0];
    end else begin
      w_jump_src = w_imm8[PC_W-1:0];
    end
    w_flag_en = aluControl & LoadAcc & SelAcc[1];
  end

  // PC, IR, accumulator and flags; jump source uses the IR from before the edge.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      r_pc  <= LP_RESET_PC;
      r_ir  <= 8'h00;
      r_acc <= 8'h00;
      r_z   <= 1'b0;
      r_c   <= 1'b0;
    end else begin
      if (LoadPC) begin
        r_pc <= w_jump_src;
      end else if (IncPC) begin
        r_pc <= r_pc + PC_W'(1);
      end
      if (LoadIR) begin
        r_ir <= InstrIn;
      end
      if (LoadAcc) begin
        r_acc <= w_acc_next;
      end
      if (w_flag_en) begin
        r_z <= (w_alu_res == 8'h00);
        r_c <= w_alu_c;
      end
    end
  end

  // Register file write port; stores the accumulator value held before the edge.
  always_ff @(posedge CLK) begin
    if (CLB) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (LoadReg) begin
      r_regs[r_ir[3:0]] <= r_acc;
    end
  end

  assign PC     = r_pc;
  assign Opcode = r_ir[7:4];
  assign z      = r_z;
  assign c      = r_c;
  assign AccOut = r_acc;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed, table-driven bench for cpu_datapath: one record per clock edge,
// followed by hand-written sequences for write-ordering, two-pass jumps and mid-op reset.
module tb_cpu_datapath;

  // control bundle bit order: {CLB, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, aluControl}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_RST  = 8'b1110_0010;
  localparam logic [7:0] C_IR   = 8'b0100_0000;
  localparam logic [7:0] C_ACC  = 8'b0000_0010;
  localparam logic [7:0] C_ALU  = 8'b0000_0011;
  localparam logic [7:0] C_REG  = 8'b0000_0100;
  localparam logic [7:0] C_JI   = 8'b0000_1000;
  localparam logic [7:0] C_JR   = 8'b0001_1000;
  localparam logic [7:0] C_INC  = 8'b0010_0000;

  typedef struct {
    string      name;
    logic [7:0] ctl;
    logic [1:0] sacc;
    logic [3:0] salu;
    logic [7:0] instr;
    logic [7:0] e_pc;
    logic [3:0] e_op;
    logic [7:0] e_acc;
    logic       e_z;
    logic       e_c;
  } vec_t;

  logic       clk;
  logic       clb, alu_c, ld_ir, inc_pc, sel_pc, ld_pc, ld_reg, ld_acc;
  logic [1:0] sel_acc;
  logic [3:0] sel_alu;
  logic [7:0] instr;
  logic [7:0] pc;
  logic [3:0] opcode;
  logic       zf, cf;
  logic [7:0] acc;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];

  cpu_datapath #(.PC_W(8), .RESET_PC(0)) dut (
    .CLK(clk), .CLB(clb), .aluControl(alu_c), .LoadIR(ld_ir), .IncPC(inc_pc),
    .SelPC(sel_pc), .LoadPC(ld_pc), .LoadReg(ld_reg), .LoadAcc(ld_acc),
    .SelAcc(sel_acc), .SelALU(sel_alu), .InstrIn(instr),
    .PC(pc), .Opcode(opcode), .z(zf), .c(cf), .AccOut(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic [7:0] ctl, input logic [1:0] sa,
                     input logic [3:0] sl, input logic [7:0] ins, input logic [7:0] epc,
                     input logic [3:0] eop, input logic [7:0] eacc, input logic ez, input logic ec);
    vec_t v;
    v.name = name; v.ctl = ctl; v.sacc = sa; v.salu = sl; v.instr = ins;
    v.e_pc = epc; v.e_op = eop; v.e_acc = eacc; v.e_z = ez; v.e_c = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [7:0] ctl, input logic [1:0] sa, input logic [3:0] sl,
                       input logic [7:0] ins);
    {clb, ld_ir, inc_pc, sel_pc, ld_pc, ld_reg, ld_acc, alu_c} = ctl;
    sel_acc = sa;
    sel_alu = sl;
    instr   = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [7:0] epc, input logic [3:0] eop,
                         input logic [7:0] eacc, input logic ez, input logic ec);
    chk({name, ".pc"}, pc, epc);
    chk({name, ".op"}, {4'h0, opcode}, {4'h0, eop});
    chk({name, ".acc"}, acc, eacc);
    chk({name, ".z"}, {7'h00, zf}, {7'h00, ez});
    chk({name, ".c"}, {7'h00, cf}, {7'h00, ec});
  endtask

  initial begin
    {clb, ld_ir, inc_pc, sel_pc, ld_pc, ld_reg, ld_acc, alu_c} = C_NONE;
    sel_acc = 2'b00; sel_alu = 4'b0000; instr = 8'h00;

    add("reset",    C_RST, 2'b00, 4'b0000, 8'hD7, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0);
    add("ir_d5",    C_IR,  2'b00, 4'b0000, 8'hD5, 8'h00, 4'hD, 8'h00, 1'b0, 1'b0);
    add("ld_imm5",  C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'hD, 8'h05, 1'b0, 1'b0);
    add("ir_53",    C_IR,  2'b00, 4'b0000, 8'h53, 8'h00, 4'h5, 8'h05, 1'b0, 1'b0);
    add("st_r3",    C_REG, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h5, 8'h05, 1'b0, 1'b0);
    add("ir_40",    C_IR,  2'b00, 4'b0000, 8'h40, 8'h00, 4'h4, 8'h05, 1'b0, 1'b0);
    add("ld_imm0",  C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h4, 8'h00, 1'b0, 1'b0);
    add("ir_43",    C_IR,  2'b00, 4'b0000, 8'h43, 8'h00, 4'h4, 8'h00, 1'b0, 1'b0);
    add("movr_r3",  C_ACC, 2'b01, 4'b0000, 8'h00, 8'h00, 4'h4, 8'h05, 1'b0, 1'b0);
    add("ir_02",    C_IR,  2'b00, 4'b0000, 8'h02, 8'h00, 4'h0, 8'h05, 1'b0, 1'b0);
    add("ld_imm2",  C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h02, 1'b0, 1'b0);
    add("shl_a",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h04, 1'b0, 1'b0);
    add("shl_b",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h08, 1'b0, 1'b0);
    add("shl_c",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h10, 1'b0, 1'b0);
    add("shl_d",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h20, 1'b0, 1'b0);
    add("ir_52",    C_IR,  2'b00, 4'b0000, 8'h52, 8'h00, 4'h5, 8'h20, 1'b0, 1'b0);
    add("st_r2",    C_REG, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h5, 8'h20, 1'b0, 1'b0);
    add("ir_0f",    C_IR,  2'b00, 4'b0000, 8'h0F, 8'h00, 4'h0, 8'h20, 1'b0, 1'b0);
    add("ld_immf",  C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h0F, 1'b0, 1'b0);
    add("shl_e",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h1E, 1'b0, 1'b0);
    add("shl_f",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h3C, 1'b0, 1'b0);
    add("shl_g",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h78, 1'b0, 1'b0);
    add("shl_h",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'hF0, 1'b0, 1'b0);
    add("ir_12",    C_IR,  2'b00, 4'b0000, 8'h12, 8'h00, 4'h1, 8'hF0, 1'b0, 1'b0);
    add("add_cy",   C_ALU, 2'b11, 4'b1000, 8'h00, 8'h00, 4'h1, 8'h10, 1'b0, 1'b1);
    add("ir_51",    C_IR,  2'b00, 4'b0000, 8'h51, 8'h00, 4'h5, 8'h10, 1'b0, 1'b1);
    add("st_r1",    C_REG, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h5, 8'h10, 1'b0, 1'b1);
    add("ir_11",    C_IR,  2'b00, 4'b0000, 8'h11, 8'h00, 4'h1, 8'h10, 1'b0, 1'b1);
    add("sub_zero", C_ALU, 2'b11, 4'b1100, 8'h00, 8'h00, 4'h1, 8'h00, 1'b1, 1'b0);
    add("ir_01",    C_IR,  2'b00, 4'b0000, 8'h01, 8'h00, 4'h0, 8'h00, 1'b1, 1'b0);
    add("ld_imm1",  C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h01, 1'b1, 1'b0);
    add("ir_11b",   C_IR,  2'b00, 4'b0000, 8'h11, 8'h00, 4'h1, 8'h01, 1'b1, 1'b0);
    add("add_11",   C_ALU, 2'b10, 4'b1000, 8'h00, 8'h00, 4'h1, 8'h11, 1'b0, 1'b0);
    add("ir_51b",   C_IR,  2'b00, 4'b0000, 8'h51, 8'h00, 4'h5, 8'h11, 1'b0, 1'b0);
    add("st_r1b",   C_REG, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h5, 8'h11, 1'b0, 1'b0);
    add("ir_42",    C_IR,  2'b00, 4'b0000, 8'h42, 8'h00, 4'h4, 8'h11, 1'b0, 1'b0);
    add("movr_r2",  C_ACC, 2'b01, 4'b0000, 8'h00, 8'h00, 4'h4, 8'h20, 1'b0, 1'b0);
    add("shr_nf",   C_ACC, 2'b10, 4'b0011, 8'h00, 8'h00, 4'h4, 8'h10, 1'b0, 1'b0);
    add("ir_11c",   C_IR,  2'b00, 4'b0000, 8'h11, 8'h00, 4'h1, 8'h10, 1'b0, 1'b0);
    add("sub_brw",  C_ALU, 2'b11, 4'b1100, 8'h00, 8'h00, 4'h1, 8'hFF, 1'b0, 1'b1);
    add("ir_08",    C_IR,  2'b00, 4'b0000, 8'h08, 8'h00, 4'h0, 8'hFF, 1'b0, 1'b1);
    add("ld_imm8",  C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h08, 1'b0, 1'b1);
    add("shl_i",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h10, 1'b0, 1'b1);
    add("shl_j",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h20, 1'b0, 1'b1);
    add("shl_k",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h40, 1'b0, 1'b1);
    add("shl_l",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0, 1'b1);
    add("ir_54",    C_IR,  2'b00, 4'b0000, 8'h54, 8'h00, 4'h5, 8'h80, 1'b0, 1'b1);
    add("st_r4",    C_REG, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h5, 8'h80, 1'b0, 1'b1);
    add("ir_01b",   C_IR,  2'b00, 4'b0000, 8'h01, 8'h00, 4'h0, 8'h80, 1'b0, 1'b1);
    add("ld_imm1b", C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h01, 1'b0, 1'b1);
    add("ir_14",    C_IR,  2'b00, 4'b0000, 8'h14, 8'h00, 4'h1, 8'h01, 1'b0, 1'b1);
    add("add_81",   C_ALU, 2'b10, 4'b1000, 8'h00, 8'h00, 4'h1, 8'h81, 1'b0, 1'b0);
    add("shl_cy",   C_ALU, 2'b11, 4'b0001, 8'h00, 8'h00, 4'h1, 8'h02, 1'b0, 1'b1);
    add("ir_01c",   C_IR,  2'b00, 4'b0000, 8'h01, 8'h00, 4'h0, 8'h02, 1'b0, 1'b1);
    add("ld_imm1c", C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h01, 1'b0, 1'b1);
    add("shr_zc",   C_ALU, 2'b10, 4'b0011, 8'h00, 8'h00, 4'h0, 8'h00, 1'b1, 1'b1);
    add("ld_imm1d", C_ACC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h0, 8'h01, 1'b1, 1'b1);
    add("ir_14b",   C_IR,  2'b00, 4'b0000, 8'h14, 8'h00, 4'h1, 8'h01, 1'b1, 1'b1);
    add("add_nf",   C_ACC, 2'b10, 4'b1000, 8'h00, 8'h00, 4'h1, 8'h81, 1'b1, 1'b1);
    add("shl_nf",   C_ACC, 2'b10, 4'b0001, 8'h00, 8'h00, 4'h1, 8'h02, 1'b1, 1'b1);
    add("nor",      C_ALU, 2'b10, 4'b0100, 8'h00, 8'h00, 4'h1, 8'h7D, 1'b0, 1'b0);
    add("pass",     C_ALU, 2'b11, 4'b0111, 8'h00, 8'h00, 4'h1, 8'h7D, 1'b0, 1'b0);
    add("ir_73",    C_IR,  2'b00, 4'b0000, 8'h73, 8'h00, 4'h7, 8'h7D, 1'b0, 1'b0);
    add("jmp_imm",  C_JI,  2'b00, 4'b0000, 8'h00, 8'h03, 4'h7, 8'h7D, 1'b0, 1'b0);
    add("ir_42b",   C_IR,  2'b00, 4'b0000, 8'h42, 8'h03, 4'h4, 8'h7D, 1'b0, 1'b0);
    add("movr_r2b", C_ACC, 2'b01, 4'b0000, 8'h00, 8'h03, 4'h4, 8'h20, 1'b0, 1'b0);
    add("shl_m",    C_ACC, 2'b10, 4'b0001, 8'h00, 8'h03, 4'h4, 8'h40, 1'b0, 1'b0);
    add("ir_52b",   C_IR,  2'b00, 4'b0000, 8'h52, 8'h03, 4'h5, 8'h40, 1'b0, 1'b0);
    add("st_r2b",   C_REG, 2'b00, 4'b0000, 8'h00, 8'h03, 4'h5, 8'h40, 1'b0, 1'b0);
    add("ir_62",    C_IR,  2'b00, 4'b0000, 8'h62, 8'h03, 4'h6, 8'h40, 1'b0, 1'b0);
    add("jmp_reg",  C_JR,  2'b00, 4'b0000, 8'h00, 8'h40, 4'h6, 8'h40, 1'b0, 1'b0);
    add("jmp_inc",  C_JI | C_INC, 2'b00, 4'b0000, 8'h00, 8'h02, 4'h6, 8'h40, 1'b0, 1'b0);
    add("jmp_oldir", C_JR | C_IR, 2'b00, 4'b0000, 8'h75, 8'h40, 4'h7, 8'h40, 1'b0, 1'b0);
    add("ir_00",    C_IR,  2'b00, 4'b0000, 8'h00, 8'h40, 4'h0, 8'h40, 1'b0, 1'b0);
    add("ld_imm0b", C_ACC, 2'b00, 4'b0000, 8'h00, 8'h40, 4'h0, 8'h00, 1'b0, 1'b0);
    add("nor_ff",   C_ACC, 2'b10, 4'b0100, 8'h00, 8'h40, 4'h0, 8'hFF, 1'b0, 1'b0);
    add("ir_59",    C_IR,  2'b00, 4'b0000, 8'h59, 8'h40, 4'h5, 8'hFF, 1'b0, 1'b0);
    add("st_r9",    C_REG, 2'b00, 4'b0000, 8'h00, 8'h40, 4'h5, 8'hFF, 1'b0, 1'b0);
    add("ir_69",    C_IR,  2'b00, 4'b0000, 8'h69, 8'h40, 4'h6, 8'hFF, 1'b0, 1'b0);
    add("jmp_ff",   C_JR,  2'b00, 4'b0000, 8'h00, 8'hFF, 4'h6, 8'hFF, 1'b0, 1'b0);
    add("pc_wrap",  C_INC, 2'b00, 4'b0000, 8'h00, 8'h00, 4'h6, 8'hFF, 1'b0, 1'b0);
    add("pc_inc",   C_INC, 2'b00, 4'b0000, 8'h00, 8'h01, 4'h6, 8'hFF, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].ctl, vecs[i].sacc, vecs[i].salu, vecs[i].instr);
      chk_all(vecs[i].name, vecs[i].e_pc, vecs[i].e_op, vecs[i].e_acc, vecs[i].e_z, vecs[i].e_c);
    end

    // Same-edge register write and accumulator load: R10 keeps the old Acc.
    drive(C_IR, 2'b00, 4'b0000, 8'h5A);
    drive(C_REG | C_ACC, 2'b00, 4'b0000, 8'h00);
    chk("regacc.acc", acc, 8'h0A);
    drive(C_IR, 2'b00, 4'b0000, 8'h4A);
    drive(C_ACC, 2'b01, 4'b0000, 8'h00);
    chk("regacc.r10", acc, 8'hFF);

    // Two-pass taken jump: IR holds across the intermediate cycle.
    drive(C_IR, 2'b00, 4'b0000, 8'h73);
    drive(C_JI, 2'b00, 4'b0000, 8'h00);
    chk_all("jump2.p1", 8'h03, 4'h7, 8'hFF, 1'b0, 1'b0);
    drive(C_IR | C_INC, 2'b00, 4'b0000, 8'hD1);
    chk_all("jump2.p2", 8'h04, 4'hD, 8'hFF, 1'b0, 1'b0);

    // Reset between the two jump passes clears everything, including flags and registers.
    drive(C_ALU, 2'b10, 4'b0001, 8'h00);
    chk_all("prerst.shl", 8'h04, 4'hD, 8'hFE, 1'b0, 1'b1);
    drive(C_JI, 2'b00, 4'b0000, 8'h00);
    chk("prerst.pc", pc, 8'h01);
    drive(C_RST, 2'b00, 4'b0000, 8'h5F);
    chk_all("midrst", 8'h00, 4'h0, 8'h00, 1'b0, 1'b0);
    drive(C_IR, 2'b00, 4'b0000, 8'h49);
    drive(C_ACC, 2'b01, 4'b0000, 8'h00);
    chk("midrst.r9", acc, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
